// File: rtl/memb_seq_ctrl.sv
// memb_seq_ctrl: sequences one tile of B rows through the skewed FIFO bank.
// Column c of the bank is a shift FIFO of depth DIM+c. A tile is loaded over
// a valid/ready handshake, then the skew is drained, and col_vld tells the
// array which bank outputs currently carry real data.
module memb_seq_ctrl #(
  parameter int DIM   = 8,
  parameter int CNT_W = $clog2(3*DIM)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   b_vld,
  output logic                   b_rdy,
  input  logic                   stall,
  output logic                   wr_en,
  output logic                   en,
  output logic [$clog2(DIM)-1:0] row_idx,
  output logic [DIM-1:0]         col_vld,
  output logic                   busy,
  output logic                   done
);

  localparam int ROW_W = $clog2(DIM);

  // Last count value before each phase boundary; the beat/shift taken at
  // this value moves the FSM on.
  localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(DIM - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(3*DIM - 3);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    FLUSH
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             done_nxt;

  // State, shift counter and the registered done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      done  <= done_nxt;
    end
  end

  // Next state: count load beats, then drain shifts; any stall freezes both.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD;
          cnt_nxt   = '0;
        end
      end
      LOAD: begin
        if (b_vld && !stall) begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == LOAD_LAST) begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!stall) begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == DRAIN_LAST) begin
            state_nxt = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (!stall) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Bank controls and column-valid mask, derived only from state, cnt and the handshake inputs.
  always_comb begin
    b_rdy   = (state == LOAD) && !stall;
    wr_en   = (state == LOAD) && !stall && b_vld;
    en      = (state == DRAIN) && !stall;
    busy    = (state != IDLE);
    row_idx = (state == LOAD) ? cnt[ROW_W-1:0] : '0;
    col_vld = '0;
    for (int c = 0; c < DIM; c++) begin
      col_vld[c] = (state != IDLE) &&
                   (cnt >= CNT_W'(DIM + c)) &&
                   (cnt <= CNT_W'(2*DIM + c - 1));
    end
  end

endmodule

// File: tb/tb_memb_seq_ctrl.sv
// tb_memb_seq_ctrl: randomized and directed tiles against a count-based
// reference model, with a bank model feeding a column-data scoreboard.
module tb_memb_seq_ctrl;

  localparam int DIM = 8;
  localparam int RW  = $clog2(DIM);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            b_vld;
  logic            b_rdy;
  logic            stall;
  logic            wr_en;
  logic            en;
  logic [RW-1:0]   row_idx;
  logic [DIM-1:0]  col_vld;
  logic            busy;
  logic            done;

  logic [7:0] din  [DIM];
  logic [7:0] bank [DIM][3*DIM];
  logic [7:0] expq [DIM][$];
  int         done_q[$];

  int cyc         = 0;
  int n_cmp       = 0;
  int n_fail      = 0;
  int en_count    = 0;
  int tile_start  = 0;
  int chain_start = 0;

  // Reference model state: tile in flight, rows accepted, drain shifts done.
  bit m_active = 1'b0;
  int m_rows   = 0;
  int m_shifts = 0;

  memb_seq_ctrl #(.DIM(DIM)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .b_vld   (b_vld),
    .b_rdy   (b_rdy),
    .stall   (stall),
    .wr_en   (wr_en),
    .en      (en),
    .row_idx (row_idx),
    .col_vld (col_vld),
    .busy    (busy),
    .done    (done)
  );

  initial forever #5 clk = ~clk;

  task automatic checkVal(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flagFail(input string name);
    n_cmp++;
    n_fail++;
    $display("[TB] FAIL %s: got event, expected none (cycle %0d)", name, cyc);
  endtask

  // Skewed bank: column c shifts whenever the bank is written or drained.
  always @(posedge clk) begin
    if (wr_en || en) begin
      for (int c = 0; c < DIM; c++) begin
        for (int p = 1; p < DIM + c; p++) begin
          bank[c][p] <= bank[c][p-1];
        end
        bank[c][0] <= wr_en ? din[c] : 8'hEE;
      end
    end
  end

  // Consumer/monitor: pops expected column data and done cycles when presented.
  always @(negedge clk) begin
    if (en) en_count++;
    for (int c = 0; c < DIM; c++) begin
      if (col_vld[c] && !stall) begin
        if (expq[c].size() == 0) begin
          flagFail($sformatf("col%0d_extra_sample", c));
        end else begin
          checkVal($sformatf("col%0d_data", c), int'(bank[c][DIM+c-1]), int'(expq[c].pop_front()));
        end
      end
    end
    if (done) begin
      if (done_q.size() == 0) flagFail("done_spurious");
      else checkVal("done_cycle", cyc, done_q.pop_front());
    end
    while (done_q.size() > 0 && done_q[0] < cyc) begin
      flagFail("done_missing");
      void'(done_q.pop_front());
    end
  end

  // Model update at a clock edge from the inputs held during the cycle just ended.
  task automatic modelEdge();
    if (!rst_n) begin
      m_active = 1'b0;
      m_rows   = 0;
      m_shifts = 0;
      for (int c = 0; c < DIM; c++) expq[c].delete();
      done_q.delete();
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1;
        m_rows   = 0;
        m_shifts = 0;
      end
    end else if (m_rows < DIM) begin
      if (b_vld && !stall) begin
        for (int c = 0; c < DIM; c++) expq[c].push_back(din[c]);
        m_rows++;
      end
    end else if (m_shifts < 2*DIM - 2) begin
      if (!stall) m_shifts++;
    end else if (!stall) begin
      m_active = 1'b0;
      done_q.push_back(cyc);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    cyc++;
    modelEdge();
  endtask

  task automatic applyStimulus(input logic s, input logic v, input logic st, input logic r);
    #1;
    start = s;
    b_vld = v;
    stall = st;
    rst_n = r;
    for (int c = 0; c < DIM; c++) din[c] = 8'($urandom_range(0, 255));
  endtask

  task automatic checkOutput();
    bit             load;
    bit             drain;
    logic [DIM-1:0] ec;
    #1;
    load  = m_active && (m_rows < DIM);
    drain = m_active && (m_rows == DIM) && (m_shifts < 2*DIM - 2);
    ec    = '0;
    for (int c = 0; c < DIM; c++) begin
      int r;
      r = m_rows + m_shifts - DIM - c;
      if (m_active && r >= 0 && r < DIM) ec[c] = 1'b1;
    end
    checkVal("busy",    int'(busy),    int'(m_active));
    checkVal("b_rdy",   int'(b_rdy),   int'(load && !stall));
    checkVal("wr_en",   int'(wr_en),   int'(load && b_vld && !stall));
    checkVal("en",      int'(en),      int'(drain && !stall));
    checkVal("row_idx", int'(row_idx), load ? m_rows : 0);
    checkVal("col_vld", int'(col_vld), int'(ec));
  endtask

  task automatic runTile(input bit randMode, input bit shape,
                         input int gapAfterRow, input int gapLen,
                         input int stallAtCnt, input int stallLen, input int flushStallLen,
                         input int busyStartAt, input int rstAtCnt, input int expLat,
                         input bit startIssued, input bit chainNext);
    int   gapCnt  = 0;
    int   stCnt   = 0;
    int   fCnt    = 0;
    int   doneCyc = -1;
    int   k;
    int   rel;
    bit   gotDone = 1'b0;
    bit   rstHit  = 1'b0;
    bit   chained = 1'b0;
    bit   load;
    bit   drain;
    bit   flush;
    logic s, v, st, r;
    if (startIssued) begin
      tile_start = chain_start;
    end else begin
      advance();
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      tile_start = cyc;
      checkOutput();
    end
    en_count = 0;
    for (int n = 0; n < 400 && !gotDone && !rstHit; n++) begin
      advance();
      k     = m_rows + m_shifts;
      load  = m_active && (m_rows < DIM);
      drain = m_active && (m_rows == DIM) && (m_shifts < 2*DIM - 2);
      flush = m_active && (m_rows == DIM) && (m_shifts == 2*DIM - 2);
      s = 1'b0; v = 1'b1; st = 1'b0; r = 1'b1;
      if (randMode) begin
        v  = ($urandom_range(0, 9) < 7);
        st = ($urandom_range(0, 9) < 2);
      end
      if (load && gapLen > 0 && m_rows == gapAfterRow + 1 && gapCnt < gapLen) begin
        v = 1'b0;
        gapCnt++;
      end
      if (drain && k == stallAtCnt && stCnt < stallLen) begin
        st = 1'b1;
        stCnt++;
      end
      if (flush && fCnt < flushStallLen) begin
        st = 1'b1;
        fCnt++;
      end
      if (busyStartAt >= 0 && cyc - tile_start == busyStartAt) s = 1'b1;
      if (drain && rstAtCnt >= 0 && k == rstAtCnt) begin
        r      = 1'b0;
        rstHit = 1'b1;
      end
      if (chainNext && !chained && !m_active) s = 1'b1;
      applyStimulus(s, v, st, r);
      if (chainNext && !chained && !m_active) begin
        chain_start = cyc;
        chained     = 1'b1;
      end
      checkOutput();
      if (shape) begin
        rel = cyc - tile_start;
        if (rel >= 1 && rel <= DIM) begin
          checkVal("nom_wr_en", int'(wr_en), 1);
          checkVal("nom_row_idx", int'(row_idx), rel - 1);
        end
        if (rel >= DIM + 1 && rel <= 3*DIM - 2) checkVal("nom_en", int'(en), 1);
        if (rel == DIM + 1)   checkVal("nom_colvld_first", int'(col_vld), 1);
        if (rel == 2*DIM)     checkVal("nom_colvld_full", int'(col_vld), (1 << DIM) - 1);
        if (rel == 3*DIM - 1) checkVal("nom_colvld_flush", int'(col_vld), 1 << (DIM - 1));
      end
      if (done) begin
        gotDone = 1'b1;
        doneCyc = cyc;
      end
    end
    if (rstHit) begin
      advance();
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      checkOutput();
      checkVal("busy_after_rst", int'(busy), 0);
      checkVal("en_after_rst", int'(en), 0);
      repeat (3) begin
        advance();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput();
      end
    end else if (!gotDone) begin
      flagFail("tile_timeout");
    end else begin
      if (expLat >= 0) checkVal("latency", doneCyc - tile_start, expLat);
      checkVal("en_count", en_count, 2*DIM - 2);
    end
  endtask

  // Watchdog so a hung DUT still ends the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish (cycle %0d)", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios first, then randomized tiles.
  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    b_vld = 1'b0;
    stall = 1'b0;
    for (int c = 0; c < DIM; c++) din[c] = 8'h00;

    $display("[TB] reset with start held high");
    repeat (3) begin
      advance();
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput();
    end
    checkVal("busy_in_reset", int'(busy), 0);
    checkVal("done_in_reset", int'(done), 0);
    repeat (2) begin
      advance();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput();
    end

    $display("[TB] nominal tile");
    runTile(1'b0, 1'b1, -1, 0, -1, 0, 0, -1, -1, 3*DIM, 1'b0, 1'b0);

    $display("[TB] upstream gap after row 2");
    runTile(1'b0, 1'b0, 2, 3, -1, 0, 0, -1, -1, 3*DIM + 3, 1'b0, 1'b0);

    $display("[TB] downstream stall in drain and flush");
    runTile(1'b0, 1'b0, -1, 0, DIM + 4, 2, 1, -1, -1, 3*DIM + 3, 1'b0, 1'b0);

    $display("[TB] start while busy, then start in done cycle");
    runTile(1'b0, 1'b1, -1, 0, -1, 0, 0, 5, -1, 3*DIM, 1'b0, 1'b1);
    runTile(1'b0, 1'b1, -1, 0, -1, 0, 0, -1, -1, 3*DIM, 1'b1, 1'b0);

    $display("[TB] reset mid-drain, then a full tile");
    runTile(1'b0, 1'b0, -1, 0, -1, 0, 0, -1, DIM + 2, -1, 1'b0, 1'b0);
    runTile(1'b0, 1'b1, -1, 0, -1, 0, 0, -1, -1, 3*DIM, 1'b0, 1'b0);

    $display("[TB] randomized tiles");
    repeat (8) begin
      repeat ($urandom_range(0, 3)) begin
        advance();
        applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        checkOutput();
      end
      runTile(1'b1, 1'b0, -1, 0, -1, 0, 0, -1, -1, -1, 1'b0, 1'b0);
    end

    repeat (3) begin
      advance();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput();
    end
    for (int c = 0; c < DIM; c++) checkVal($sformatf("col%0d_left", c), expq[c].size(), 0);
    checkVal("done_left", done_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
